// File: rtl/mux_stream_scheduler_pkg.sv
// Shared encodings for the stream routing mux and its round-robin scheduler.
package mux_stream_scheduler_pkg;

  localparam int NUM_EP = 5;

  localparam logic [2:0] SEL_IDLE = 3'd0;
  localparam logic [2:0] SEL_M1   = 3'd1;
  localparam logic [2:0] SEL_M2   = 3'd2;
  localparam logic [2:0] SEL_S1   = 3'd3;
  localparam logic [2:0] SEL_S2   = 3'd4;
  localparam logic [2:0] SEL_S3   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GUARD,
    ST_ACTIVE,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/mux_stream_scheduler_rr_arbiter5.sv
// Combinational round-robin pick over five requesters, searching upward from ptr+1.
module rr_arbiter5
  import mux_stream_scheduler_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic       valid,
  output logic [2:0] idx,
  output logic [4:0] onehot
);

  logic [2:0] cand;

  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = '0;
    for (int i = 1; i <= NUM_EP; i++) begin
      cand = 3'((int'(ptr) + i) % NUM_EP);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    if (valid) onehot = 5'd1 << idx;
  end

endmodule

// File: rtl/mux_stream_scheduler.sv
// Owns the routing mux select: grants one endpoint at a time, guards the switch,
// and releases on tlast handshake or stall timeout.
module mux_stream_scheduler
  import mux_stream_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8,
  parameter int GUARD_CYCLES   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [4:0]       req,
  input  logic             tvalid,
  input  logic             tready,
  input  logic             tlast,
  output logic [2:0]       sel,
  output logic [4:0]       grant,
  output logic             go,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] beat_count
);

  localparam logic [3:0]       GUARD_LAST = 4'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_LIM  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] BEAT_MAX   = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d, win_q, win_d, sel_q, sel_d;
  logic [4:0]       grant_q, grant_d;
  logic             go_q, go_d, busy_q, busy_d, done_q, done_d, tmo_q, tmo_d;
  logic [CNT_W-1:0] beat_q, beat_d, stall_q, stall_d;
  logic [3:0]       guard_q, guard_d;

  logic       arb_valid;
  logic [2:0] arb_idx;
  logic [4:0] arb_onehot;
  logic       hs;

  rr_arbiter5 u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (arb_valid),
    .idx    (arb_idx),
    .onehot (arb_onehot)
  );

  assign hs = tvalid & tready & go_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    stall_d = stall_q;
    guard_d = guard_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && arb_valid) begin
          state_d = ST_GUARD;
          win_d   = arb_idx;
          sel_d   = SEL_M1 + arb_idx;
          grant_d = arb_onehot;
          beat_d  = '0;
          stall_d = '0;
          guard_d = '0;
        end
      end
      ST_GUARD: begin
        if (guard_q == GUARD_LAST) state_d = ST_ACTIVE;
        else                       guard_d = guard_q + 4'd1;
      end
      ST_ACTIVE: begin
        if (hs) begin
          if (beat_q != BEAT_MAX) beat_d = beat_q + 1'b1;
          stall_d = '0;
        end else begin
          stall_d = stall_q + 1'b1;
        end
        // A closing handshake takes precedence over a coincident timeout.
        if (hs && tlast) begin
          state_d = ST_RELEASE;
          done_d  = 1'b1;
        end else if (stall_q == STALL_LIM) begin
          state_d = ST_RELEASE;
          tmo_d   = 1'b1;
        end
        if (state_d == ST_RELEASE) begin
          ptr_d   = win_q;
          sel_d   = SEL_IDLE;
          grant_d = '0;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    go_d   = (state_d == ST_ACTIVE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd4;
      win_q   <= '0;
      sel_q   <= SEL_IDLE;
      grant_q <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      beat_q  <= '0;
      stall_q <= '0;
      guard_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      beat_q  <= beat_d;
      stall_q <= stall_d;
      guard_q <= guard_d;
    end
  end

  assign sel         = sel_q;
  assign grant       = grant_q;
  assign go          = go_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = tmo_q;
  assign beat_count  = beat_q;

endmodule

// File: tb/tb_mux_stream_scheduler.sv
// Directed scenarios plus a randomized run, checked every cycle against a packet-level model.
module tb_mux_stream_scheduler;

  localparam int TMO = 10;
  localparam int GRD = 1;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst_n, enable, tvalid, tready, tlast;
  logic [4:0]    req;
  logic [2:0]    sel;
  logic [4:0]    grant;
  logic          go, busy, done, timeout_err;
  logic [CW-1:0] beat_count;

  mux_stream_scheduler #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW), .GUARD_CYCLES(GRD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
    .tvalid(tvalid), .tready(tready), .tlast(tlast),
    .sel(sel), .grant(grant), .go(go), .busy(busy), .done(done),
    .timeout_err(timeout_err), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  // model: phase 0 idle, 1 guard, 2 active, 3 release
  int m_phase = 0, m_owner = 0, m_ptr = 4, m_guard = 0, m_stall = 0, m_beats = 0;
  bit m_done = 0, m_tmo = 0;
  int go_rise_cyc = 0, tmo_cyc = 0, done_cnt = 0;
  bit go_prev = 0;
  int sel_log[$];
  int t0, n0, busy_seen, bias;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic model_step();
    bit hs;
    int c;
    m_done = 0;
    m_tmo  = 0;
    if (!rst_n) begin
      m_phase = 0; m_ptr = 4; m_beats = 0;
      return;
    end
    case (m_phase)
      0: if (enable && req != 5'd0) begin
           for (int k = 1; k <= 5; k++) begin
             c = (m_ptr + k) % 5;
             if (req[c[2:0]]) begin m_owner = c; break; end
           end
           m_phase = 1; m_beats = 0; m_guard = 0; m_stall = 0;
         end
      1: begin
           m_guard++;
           if (m_guard == GRD) m_phase = 2;
         end
      2: begin
           hs = tvalid && tready;
           if (hs && m_beats < 255) m_beats++;
           if (hs && tlast) begin
             m_phase = 3; m_done = 1; m_ptr = m_owner;
           end else if (m_stall == TMO) begin
             m_phase = 3; m_tmo = 1; m_ptr = m_owner;
           end
           m_stall = hs ? 0 : m_stall + 1;
         end
      default: m_phase = 0;
    endcase
  endtask

  task automatic step();
    int es;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    es = (m_phase == 1 || m_phase == 2) ? m_owner + 1 : 0;
    chk("sel", 32'(sel), es);
    chk("grant", 32'(grant), es != 0 ? (1 << m_owner) : 0);
    chk("go", 32'(go), 32'(m_phase == 2));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("done", 32'(done), 32'(m_done));
    chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
    chk("beat_count", 32'(beat_count), m_beats);
    if (go === 1'b1 && !go_prev) begin go_rise_cyc = cyc; sel_log.push_back(int'(sel)); end
    go_prev = (go === 1'b1);
    if (timeout_err === 1'b1) tmo_cyc = cyc;
    if (done === 1'b1) done_cnt++;
  endtask

  // Drive one packet of len beats (len 0 = never tlast) until done or timeout.
  task automatic run_pkt(input int len, input int bound);
    int n = 0;
    int k = 0;
    bit hs_now;
    while (1) begin
      tlast  = (n == len - 1);
      hs_now = (m_phase == 2) && tvalid && tready;
      step();
      if (hs_now) n++;
      if (done === 1'b1 || timeout_err === 1'b1) break;
      k++;
      if (k >= bound) begin bound_fail("pkt_bound"); break; end
    end
    tlast = 1'b0;
  endtask

  task automatic wait_go(input int bound);
    int k = 0;
    while (go !== 1'b1) begin
      step();
      k++;
      if (k >= bound) begin bound_fail("go_bound"); break; end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; req = '0; tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
    step(); step();
    chk("rst_sel", 32'(sel), 0);
    chk("rst_beats", 32'(beat_count), 0);
    rst_n = 1'b1;
    step();

    // single request, 3-beat packet
    req = 5'b00100; enable = 1'b1; tvalid = 1'b1; tready = 1'b1;
    t0 = cyc; n0 = done_cnt; sel_log.delete();
    run_pkt(3, 50);
    chk("s1_go_rise", go_rise_cyc, t0 + 2);
    chk("s1_sel", sel_log[0], 3);
    chk("s1_beats", 32'(beat_count), 3);
    chk("s1_done_once", done_cnt - n0, 1);
    chk("s1_sel_rel", 32'(sel), 0);
    chk("s1_done_cyc", cyc, t0 + 5);
    req = '0; step();

    // fairness with all requests held
    do_reset();
    req = 5'b11111; sel_log.delete();
    for (int p = 0; p < 6; p++) run_pkt(1, 50);
    chk("s2_count", sel_log.size(), 6);
    for (int p = 0; p < 6; p++) chk("s2_order", sel_log[p], (p % 5) + 1);

    // stall timeout on master2
    req = 5'b00010; tvalid = 1'b1; tready = 1'b0; n0 = done_cnt;
    run_pkt(0, 60);
    chk("s3_tmo_lat", tmo_cyc - go_rise_cyc, 11);
    chk("s3_tmo", 32'(timeout_err), 1);
    chk("s3_no_done", done_cnt - n0, 0);
    chk("s3_sel_rel", 32'(sel), 0);
    req = 5'b11111; tready = 1'b1;
    run_pkt(1, 50);
    chk("s3_next_sel", sel_log[$], 3);

    // tlast handshake coincides with the timeout limit
    req = 5'b00001; tready = 1'b0; tlast = 1'b0;
    wait_go(20);
    for (int k = 0; k < TMO; k++) step();
    tready = 1'b1; tlast = 1'b1;
    step();
    chk("s4_done", 32'(done), 1);
    chk("s4_tmo", 32'(timeout_err), 0);
    tlast = 1'b0; req = '0; step();

    // reset mid-packet
    req = 5'b00100; tvalid = 1'b1; tready = 1'b1;
    begin
      int k = 0;
      while (beat_count !== 8'd2) begin
        step(); k++;
        if (k >= 30) begin bound_fail("s5_beats_bound"); break; end
      end
    end
    n0 = done_cnt;
    rst_n = 1'b0;
    step();
    chk("s5_sel", 32'(sel), 0);
    chk("s5_go", 32'(go), 0);
    chk("s5_pulses", 32'({done, timeout_err}), 0);
    rst_n = 1'b1;
    req = 5'b11111;
    run_pkt(1, 50);
    chk("s5_next_sel", sel_log[$], 1);
    chk("s5_one_done", done_cnt - n0, 1);

    // enable dropped during ACTIVE
    req = 5'b01000; tvalid = 1'b1; tready = 1'b0;
    wait_go(20);
    enable = 1'b0; req = 5'b11111; tready = 1'b1;
    run_pkt(2, 30);
    chk("s6_done", 32'(done), 1);
    busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (busy !== 1'b0) busy_seen++;
    end
    chk("s6_no_grant", busy_seen, 0);

    // beat_count saturation on a long packet
    enable = 1'b1; req = 5'b10000; tvalid = 1'b1; tready = 1'b1;
    run_pkt(300, 400);
    chk("s7_sat", 32'(beat_count), 255);
    req = '0; step();

    // randomized traffic
    bias = 70;
    for (int k = 0; k < 3000; k++) begin
      if (k % 150 == 0) bias = (($urandom_range(0, 2) == 0) ? 3 : 75);
      rst_n  = ($urandom_range(0, 299) != 0);
      enable = ($urandom_range(0, 9) != 0);
      req    = 5'($urandom);
      tvalid = ($urandom_range(0, 3) != 0);
      tready = ($urandom_range(0, 99) < bias);
      tlast  = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_stream_scheduler.md
Name: mux_stream_scheduler

Overview:
- Round-robin scheduler that owns the 3-bit `sel` of the stream routing mux.
- The mux routes one upstream byte stream (tdata/tvalid/tlast, tready returned) to one of five endpoints: master1, master2, slave1, slave2, slave3.
- Endpoints raise requests. The scheduler picks one, drives `sel`, and tells the stream source when it may send.
- It holds the route until the packet closes with a tlast handshake or a stall timeout fires, then releases `sel` to idle.

Parameters:
- TIMEOUT_CYCLES, 255: consecutive cycles in ACTIVE without a handshake before the route is forcibly released. Legal range 1..(2^CNT_W − 1).
- CNT_W, 8: width of the stall counter and of `beat_count`.
- GUARD_CYCLES, 1: cycles `sel` is held stable before `go` asserts. Legal range 1..15.

Ports:
- clk, in, 1: clock. All logic on the rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- enable, in, 1: when 0, no new grant starts. A grant already in progress completes normally.
- req, in, 5: endpoint requests. bit0 = master1, bit1 = master2, bit2 = slave1, bit3 = slave2, bit4 = slave3.
- tvalid, in, 1: upstream stream valid (mux input side).
- tready, in, 1: ready returned by the mux from the selected endpoint.
- tlast, in, 1: upstream stream last.
- sel, out, 3: mux select, registered. 0 = idle; 1..5 = master1, master2, slave1, slave2, slave3.
- grant, out, 5: one-hot copy of `sel`, same bit order as `req`; all zero when idle.
- go, out, 1: stream source may assert tvalid; high only in ACTIVE.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle pulse on the cycle after the tlast handshake is accepted.
- timeout_err, out, 1: one-cycle pulse when the route is released by timeout.
- beat_count, out, CNT_W: handshakes in the current or last packet. Saturates at all-ones.

Behaviour:
- Reset (rst_n = 0 at a clock edge):
  - state = IDLE; sel = 0; grant = 0; go = 0; busy = 0; done = 0; timeout_err = 0; beat_count = 0.
  - Round-robin pointer = 4, so master1 has highest priority after reset.
  - Reset mid-packet abandons the packet at once. No done pulse, no timeout_err pulse.
- Handshake is defined as tvalid & tready & go.
- FSM states: IDLE, GUARD, ACTIVE, RELEASE.
- IDLE:
  - If enable & |req: pick the first set req bit searching upward from pointer+1, wrapping modulo 5.
  - Register sel/grant for the winner, clear beat_count and the guard counter, go to GUARD.
  - `sel` changes one cycle after the req sample.
- GUARD:
  - Count GUARD_CYCLES cycles with sel stable and go = 0, then go to ACTIVE.
  - req changes are ignored in this state.
- ACTIVE:
  - go = 1.
  - Each handshake: beat_count += 1 (saturating) and the stall counter clears.
  - Each cycle without a handshake: the stall counter increments.
  - Handshake with tlast = 1: go to RELEASE, set done pulse pending, pointer = winner index.
  - Stall counter reaches TIMEOUT_CYCLES: go to RELEASE, set timeout_err pulse pending, pointer = winner index.
  - If a tlast handshake and the timeout limit occur in the same cycle, the handshake wins: done, not timeout_err.
  - Deasserting the winner's req mid-packet has no effect; packets are never truncated by req.
- RELEASE (one cycle):
  - sel = 0, grant = 0, go = 0.
  - done or timeout_err pulses high in this cycle.
  - Next state is IDLE, so at least one idle sel = 0 cycle separates consecutive grants.
- Back-to-back: with requests still pending, the minimum period per packet is 1 (IDLE) + GUARD_CYCLES + beats + stall cycles + 1 (RELEASE).
- beat_count holds its value through RELEASE and IDLE until the next grant.
- Fairness: with all five requests held continuously, the grant order is 1, 2, 3, 4, 5, 1, …; no requester is starved.

Decomposition:
- Shared package:
  - sel encodings SEL_IDLE = 0, SEL_M1 = 1, SEL_M2 = 2, SEL_S1 = 3, SEL_S2 = 4, SEL_S3 = 5, also used by the routing mux.
  - Endpoint count NUM_EP = 5.
  - FSM state enum.
- One sub-module, rr_arbiter5: combinational round-robin pick. Inputs: req[4:0], ptr[2:0]. Outputs: valid, idx[2:0], onehot[4:0]. The FSM and counters stay in the top level.

Test Plan:
- Reset then single request: req = 5'b00100, enable = 1, 3-beat packet, tready = 1.
  - sel = 3 one cycle after the req sample; go rises after 1 guard cycle; beat_count = 3; done pulses once; sel returns to 0.
- All requests held, 5 one-beat packets: grant sequence 1, 2, 3, 4, 5, with one sel = 0 cycle between each.
  - A sixth packet grants sel = 1 again.
- Stall timeout: TIMEOUT_CYCLES = 10, sel = 2, tvalid = 1, tready = 0.
  - timeout_err pulses 11 cycles after go rises; done stays 0; sel returns to 0; pointer advances past master2.
- Simultaneous tlast handshake and timeout limit in one cycle: done = 1, timeout_err = 0.
- Reset mid-packet after 2 beats: the next cycle shows sel = 0 and go = 0 with no done/timeout pulse; next grant goes to master1 under the reset pointer.
- enable dropped during ACTIVE: current packet completes with done; no further grant while enable = 0 even with req = 5'b11111.
